// File: rtl/arp_resolve_ctrl_pkg.sv
// ==========================================================================
// arp_resolve_ctrl_pkg : shared encodings for the UDP TX ARP resolver
// rev 1.0
// ==========================================================================
`default_nettype none

package arp_resolve_ctrl_pkg;

  localparam logic [31:0] IP_BCAST  = 32'hFFFF_FFFF;
  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MAC_NONE  = 48'h0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WAIT_LKP  = 3'd2,
    ST_SEND_ARP  = 3'd3,
    ST_WAIT_RPLY = 3'd4,
    ST_DONE      = 3'd5
  } arp_state_t;

  // An all-zero MAC in the cache means the entry was never filled.
  function automatic logic mac_is_hit(input logic [47:0] mac);
    return (mac != MAC_NONE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/arp_resolve_ctrl_if.sv
// ==========================================================================
// arp_resolve_ctrl_if : requester, cache-read and ARP TX/RX signal bundle
// rev 1.0
// ==========================================================================
`default_nettype none

interface arp_resolve_ctrl_if;

  // requester
  logic        I_req;
  logic [31:0] I_req_ip;
  logic        O_busy;
  logic        O_done;
  logic [47:0] O_mac;
  logic        O_fail;

  // MAC cache read port
  logic        O_cache_ren;
  logic [31:0] O_cache_rip;
  logic [47:0] I_cache_mac;
  logic        I_cache_done;

  // ARP TX request / ARP RX reply
  logic        O_arp_valid;
  logic [31:0] O_arp_ip;
  logic        I_arp_ready;
  logic        I_reply_valid;
  logic [31:0] I_reply_ip;
  logic [47:0] I_reply_mac;

  // The resolver itself is the slave side of this bundle.
  modport slave (
    input  I_req, I_req_ip,
    output O_busy, O_done, O_mac, O_fail,
    output O_cache_ren, O_cache_rip,
    input  I_cache_mac, I_cache_done,
    output O_arp_valid, O_arp_ip,
    input  I_arp_ready,
    input  I_reply_valid, I_reply_ip, I_reply_mac
  );

  modport master (
    output I_req, I_req_ip,
    input  O_busy, O_done, O_mac, O_fail,
    input  O_cache_ren, O_cache_rip,
    output I_cache_mac, I_cache_done,
    input  O_arp_valid, O_arp_ip,
    output I_arp_ready,
    output I_reply_valid, I_reply_ip, I_reply_mac
  );

endinterface

`default_nettype wire

// File: rtl/arp_resolve_ctrl.sv
// ==========================================================================
// arp_resolve_ctrl : cache lookup, then ARP request/retry, IP->MAC resolver
// rev 1.0
// ==========================================================================
`default_nettype none

module arp_resolve_ctrl
  import arp_resolve_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 12_500_000,
  parameter int MAX_RETRY      = 3
) (
  input  wire logic         I_clk,
  input  wire logic         I_reset_n,
  arp_resolve_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

  arp_state_t    state;
  logic [31:0]   ip_r;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;

  logic reply_match;
  logic timer_expired;

  assign reply_match   = bus.I_reply_valid && (bus.I_reply_ip == ip_r);
  assign timer_expired = (timer == TIMER_LAST);

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state           <= ST_IDLE;
      ip_r            <= '0;
      timer           <= '0;
      retry           <= '0;
      bus.O_busy      <= 1'b0;
      bus.O_done      <= 1'b0;
      bus.O_mac       <= '0;
      bus.O_fail      <= 1'b0;
      bus.O_cache_ren <= 1'b0;
      bus.O_cache_rip <= '0;
      bus.O_arp_valid <= 1'b0;
      bus.O_arp_ip    <= '0;
    end else begin
      bus.O_done      <= 1'b0;
      bus.O_cache_ren <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (bus.I_req) begin
            ip_r            <= bus.I_req_ip;
            bus.O_cache_rip <= bus.I_req_ip;
            bus.O_fail      <= 1'b0;
            bus.O_busy      <= 1'b1;
            if (bus.I_req_ip == IP_BCAST) begin
              bus.O_mac  <= MAC_BCAST;
              bus.O_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              bus.O_mac       <= MAC_NONE;
              bus.O_cache_ren <= 1'b1;
              state           <= ST_LOOKUP;
            end
          end
        end

        // Read strobe is already on the bus for this one cycle.
        ST_LOOKUP: begin
          state <= ST_WAIT_LKP;
        end

        ST_WAIT_LKP: begin
          if (bus.I_cache_done) begin
            if (mac_is_hit(bus.I_cache_mac)) begin
              bus.O_mac  <= bus.I_cache_mac;
              bus.O_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              retry           <= '0;
              bus.O_arp_valid <= 1'b1;
              bus.O_arp_ip    <= ip_r;
              state           <= ST_SEND_ARP;
            end
          end
        end

        ST_SEND_ARP: begin
          if (bus.I_arp_ready) begin
            bus.O_arp_valid <= 1'b0;
            retry           <= (retry == RETRY_LAST) ? retry : retry + RW'(1);
            timer           <= '0;
            state           <= ST_WAIT_RPLY;
          end
        end

        // A matching reply takes priority over a simultaneous timeout.
        ST_WAIT_RPLY: begin
          timer <= timer_expired ? timer : timer + TW'(1);
          if (reply_match) begin
            bus.O_mac  <= bus.I_reply_mac;
            bus.O_done <= 1'b1;
            state      <= ST_DONE;
          end else if (timer_expired) begin
            if (retry < RETRY_LAST) begin
              bus.O_arp_valid <= 1'b1;
              bus.O_arp_ip    <= ip_r;
              state           <= ST_SEND_ARP;
            end else begin
              bus.O_fail <= 1'b1;
              bus.O_mac  <= MAC_NONE;
              bus.O_done <= 1'b1;
              state      <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          bus.O_busy <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          bus.O_busy      <= 1'b0;
          bus.O_arp_valid <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arp_resolve_ctrl.sv
// ==========================================================================
// tb_arp_resolve_ctrl : scoreboard bench with cache and ARP TX/RX models
// rev 1.0
// ==========================================================================
`default_nettype none

module tb_arp_resolve_ctrl;

  localparam int TIMEOUT_CYCLES = 100;
  localparam int MAX_RETRY      = 3;
  localparam int BUDGET         = 2000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arp_resolve_ctrl_if bus ();

  arp_resolve_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRY      (MAX_RETRY)
  ) dut (
    .I_clk     (clk),
    .I_reset_n (rst_n),
    .bus       (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- cache model: 4 entries, answers one cycle after ren
  logic [31:0] c_ip  [4] = '{32'hC0A8_0164, 32'h0A00_0001, 32'h0A00_0002, 32'h0A00_0003};
  logic [47:0] c_mac [4] = '{48'h000A_3501_0203, 48'h0, 48'h0, 48'h0};

  function automatic logic [47:0] cache_lookup(input logic [31:0] ip);
    logic [47:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (c_ip[i] == ip) m = c_mac[i];
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.I_cache_done <= 1'b0;
      bus.I_cache_mac  <= '0;
    end else begin
      bus.I_cache_done <= bus.O_cache_ren;
      bus.I_cache_mac  <= cache_lookup(bus.O_cache_rip);
    end
  end

  // ---------------- ARP RX model: up to two replies, delayed from each ARP accept
  logic        plan_en    [2];
  int          plan_delay [2];
  logic [31:0] plan_ip    [2];
  logic [47:0] plan_mac   [2];
  int          rcnt       [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.I_reply_valid <= 1'b0;
      bus.I_reply_ip    <= '0;
      bus.I_reply_mac   <= '0;
      rcnt[0]           <= 0;
      rcnt[1]           <= 0;
    end else begin
      bus.I_reply_valid <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (bus.O_arp_valid && bus.I_arp_ready && plan_en[k]) begin
          rcnt[k] <= plan_delay[k];
        end else if (rcnt[k] > 0) begin
          rcnt[k] <= rcnt[k] - 1;
          if (rcnt[k] == 1) begin
            bus.I_reply_valid <= 1'b1;
            bus.I_reply_ip    <= plan_ip[k];
            bus.I_reply_mac   <= plan_mac[k];
          end
        end
      end
    end
  end

  // ---------------- monitors
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ren_cnt = 0;
  int arp_cnt = 0;
  int hs_cyc[$];
  always @(posedge clk) begin
    if (rst_n && bus.O_cache_ren) ren_cnt++;
    if (rst_n && bus.O_arp_valid && bus.I_arp_ready) begin
      arp_cnt++;
      hs_cyc.push_back(cyc);
    end
  end

  typedef struct packed {
    logic [47:0] mac;
    logic        fail;
  } result_t;

  result_t exp_q[$];
  result_t obs_q[$];
  int done_cnt = 0;
  int done_cyc = 0;
  always @(negedge clk) begin
    if (bus.O_done) begin
      obs_q.push_back({bus.O_mac, bus.O_fail});
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- stimulus helpers
  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"},      bus.O_busy,      0);
    check_val({tag, "_done"},      bus.O_done,      0);
    check_val({tag, "_mac"},       bus.O_mac,       0);
    check_val({tag, "_fail"},      bus.O_fail,      0);
    check_val({tag, "_cache_ren"}, bus.O_cache_ren, 0);
    check_val({tag, "_cache_rip"}, bus.O_cache_rip, 0);
    check_val({tag, "_arp_valid"}, bus.O_arp_valid, 0);
    check_val({tag, "_arp_ip"},    bus.O_arp_ip,    0);
  endtask

  task automatic start_req(input logic [31:0] ip);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (!bus.O_busy) begin seen = 1'b1; break; end
    end
    if (!seen) check_val("idle_timeout", 0, 1);
    bus.I_req    = 1'b1;
    bus.I_req_ip = ip;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (bus.O_busy) begin seen = 1'b1; break; end
    end
    bus.I_req = 1'b0;
    if (!seen) check_val("accept_timeout", 0, 1);
  endtask

  // Drives one request, pushes its expected result and scores the DUT result.
  task automatic do_req(input string tag, input logic [31:0] ip,
                        input logic [47:0] exp_mac, input logic exp_fail,
                        output int lat);
    int      start;
    int      t0;
    bit      seen;
    result_t e;
    result_t o;
    exp_q.push_back({exp_mac, exp_fail});
    start = done_cnt;
    t0    = cyc + 1;
    start_req(ip);
    t0    = (t0 > cyc) ? cyc : t0;
    seen  = (done_cnt != start);
    for (int i = 0; i < BUDGET && !seen; i++) begin
      @(negedge clk); #1;
      if (done_cnt != start) seen = 1'b1;
    end
    if (!seen) check_val({tag, "_done_timeout"}, 0, 1);
    lat = done_cyc - t0;
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check_val({tag, "_mac"},  o.mac,  e.mac);
      check_val({tag, "_fail"}, o.fail, e.fail);
    end else begin
      check_val({tag, "_no_result"}, obs_q.size(), 1);
    end
  endtask

  // ---------------- test sequence
  initial begin
    int lat;
    int ren0;
    int arp0;
    int hs0;
    bit seen;

    bus.I_req       = 1'b0;
    bus.I_req_ip    = '0;
    bus.I_arp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      plan_en[k]    = 1'b0;
      plan_delay[k] = 0;
      plan_ip[k]    = '0;
      plan_mac[k]   = '0;
    end

    repeat (4) @(negedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: cache hit
    ren0 = ren_cnt; arp0 = arp_cnt;
    do_req("hit", 32'hC0A8_0164, 48'h000A_3501_0203, 1'b0, lat);
    check_val("hit_cache_reads", ren_cnt - ren0, 1);
    check_val("hit_arp_reqs",    arp_cnt - arp0, 0);

    // 2: miss, matching reply 50 cycles after the ARP accept
    plan_en[0] = 1'b1; plan_delay[0] = 50;
    plan_ip[0] = 32'hC0A8_0132; plan_mac[0] = 48'h0211_2233_4455;
    ren0 = ren_cnt; arp0 = arp_cnt;
    do_req("miss", 32'hC0A8_0132, 48'h0211_2233_4455, 1'b0, lat);
    check_val("miss_cache_reads", ren_cnt - ren0, 1);
    check_val("miss_arp_reqs",    arp_cnt - arp0, 1);
    plan_en[0] = 1'b0;

    // 3: broadcast shortcut
    ren0 = ren_cnt; arp0 = arp_cnt;
    do_req("bcast", 32'hFFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b0, lat);
    check_val("bcast_latency_le2", (lat <= 2), 1);
    check_val("bcast_cache_reads", ren_cnt - ren0, 0);
    check_val("bcast_arp_reqs",    arp_cnt - arp0, 0);

    // 4: no reply; each attempt waits TIMEOUT_CYCLES plus one SEND_ARP cycle
    ren0 = ren_cnt; arp0 = arp_cnt; hs0 = hs_cyc.size();
    do_req("timeout", 32'h0A00_0009, 48'h0, 1'b1, lat);
    check_val("timeout_arp_reqs", arp_cnt - arp0, MAX_RETRY);
    if (hs_cyc.size() >= hs0 + 3) begin
      check_val("timeout_gap1", hs_cyc[hs0+1] - hs_cyc[hs0],   TIMEOUT_CYCLES + 1);
      check_val("timeout_gap2", hs_cyc[hs0+2] - hs_cyc[hs0+1], TIMEOUT_CYCLES + 1);
    end

    // 5: ARP TX backpressure, wrong-IP reply first, then matching reply
    bus.I_arp_ready = 1'b0;
    plan_en[0] = 1'b1; plan_delay[0] = 10;
    plan_ip[0] = 32'hC0A8_0133; plan_mac[0] = 48'h0666_6666_6666;
    plan_en[1] = 1'b1; plan_delay[1] = 30;
    plan_ip[1] = 32'hC0A8_013C; plan_mac[1] = 48'h0277_8899_AABB;
    arp0 = arp_cnt;
    exp_q.push_back({48'h0277_8899_AABB, 1'b0});
    begin
      int start;
      result_t e;
      result_t o;
      start = done_cnt;
      start_req(32'hC0A8_013C);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (bus.O_arp_valid) begin seen = 1'b1; break; end
        @(negedge clk); #1;
      end
      check_val("bp_valid_rise", seen, 1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk); #1;
        check_val("bp_valid_held", bus.O_arp_valid, 1);
        check_val("bp_ip_stable",  bus.O_arp_ip,    32'hC0A8_013C);
      end
      bus.I_arp_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < BUDGET && !seen; i++) begin
        @(negedge clk); #1;
        if (done_cnt != start) seen = 1'b1;
      end
      if (!seen) check_val("bp_done_timeout", 0, 1);
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        check_val("bp_mac",  o.mac,  e.mac);
        check_val("bp_fail", o.fail, e.fail);
      end else begin
        check_val("bp_no_result", obs_q.size(), 1);
      end
    end
    check_val("bp_arp_reqs", arp_cnt - arp0, 1);
    plan_en[0] = 1'b0;
    plan_en[1] = 1'b0;

    // 6: reset while waiting for a reply, then a fresh request
    arp0 = arp_cnt;
    start_req(32'hC0A8_0146);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (arp_cnt != arp0) begin seen = 1'b1; break; end
    end
    check_val("rst_arp_sent", seen, 1);
    repeat (20) @(negedge clk);
    #1 check_val("rst_busy_before", bus.O_busy, 1);
    rst_n = 1'b0;
    #1 check_all_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_req("after_rst", 32'hC0A8_0164, 48'h000A_3501_0203, 1'b0, lat);

    repeat (5) @(negedge clk);
    check_val("extra_done", obs_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "global time limit");
  end

endmodule

`default_nettype wire
